// File: rtl/ir_block_loader_pkg.sv
// ---------------------------------------------------------------------------
// ir_block_loader_pkg
// Shared definitions for the IR block loader and its neighbours.
//   - IR_DATA_WIDTH / IR_ADDR_WIDTH : default word and address widths, also
//     used by the instruction cache and the IR register file.
//   - LAT_CNT_WIDTH                 : width of the cache-latency counter
//     (CACHE_RD_LAT is limited to 1..4, so a wait of at most 3 cycles).
//   - ST_* / ir_load_state_e        : 4-bit loader state encoding.
// ---------------------------------------------------------------------------
package ir_block_loader_pkg;

  localparam int IR_DATA_WIDTH = 8;
  localparam int IR_ADDR_WIDTH = 8;
  localparam int LAT_CNT_WIDTH = 2;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_INIT  = 4'd1;
  localparam logic [3:0] ST_RD_P0 = 4'd2;
  localparam logic [3:0] ST_RD_P1 = 4'd3;
  localparam logic [3:0] ST_RD_P2 = 4'd4;
  localparam logic [3:0] ST_ISSUE = 4'd5;
  localparam logic [3:0] ST_WAIT  = 4'd6;
  localparam logic [3:0] ST_WRITE = 4'd7;
  localparam logic [3:0] ST_DONE  = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_INIT  = ST_INIT,
    S_RD_P0 = ST_RD_P0,
    S_RD_P1 = ST_RD_P1,
    S_RD_P2 = ST_RD_P2,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE
  } ir_load_state_e;

endpackage

// File: rtl/ir_block_loader_latency_cnt.sv
// ---------------------------------------------------------------------------
// ir_load_latency_cnt
// Loadable down-counter that times the cache read latency.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (count cleared to 0)
//   load_i       : load load_val_i (has priority over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one; saturates at zero
//   count_o      : current count
//   zero_o       : count is zero
//   last_o       : count is one, i.e. this decrement brings it to zero
// ---------------------------------------------------------------------------
module ir_load_latency_cnt
  import ir_block_loader_pkg::*;
#(
  parameter int WIDTH = LAT_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);
  assign last_o  = (count_q == WIDTH'(1));

endmodule

// File: rtl/ir_block_loader.sv
// ---------------------------------------------------------------------------
// ir_block_loader
// Copies a block of instruction words from the instruction cache into the IR
// register file. Source, destination and word count come either from three
// parameter words on i_data (i_en) or from the INIT_* parameters (i_init).
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   i_en            : start a parameter fetch (sampled in IDLE only)
//   i_init          : start an init load, wins over i_en (IDLE only)
//   i_abort         : cancel a transfer in progress, back to IDLE next cycle
//   i_data          : parameter word, consumed in each cycle o_read_p=1
//   o_read_p        : parameter-word consume strobe (src, dst, cnt in order)
//   o_cache_ren     : cache read request, o_cache_addr the address
//   i_cache_data    : cache read data, CACHE_RD_LAT cycles after o_cache_ren
//   o_ir_wen        : IR write enable, with o_ir_addr / o_ir_wdata
//   o_busy          : high in every state except IDLE
//   o_done          : one-cycle completion pulse (not raised on abort/reset)
//   o_checksum      : XOR of the words written by the current/last transfer
//                     (present only when IR_LOAD_CHECKSUM_EN is defined)
//
// Strobe protocol: every strobe here is a single-cycle qualifier with no
// back-pressure. o_read_p=1 means i_data is taken at the closing clock edge;
// o_cache_ren=1 means the cache must return data exactly CACHE_RD_LAT cycles
// later; o_ir_wen=1 means the regfile must write at the closing edge.
//
// Optional feature macro: IR_LOAD_CHECKSUM_EN.
// CACHE_RD_LAT must lie in 1..4.
// ---------------------------------------------------------------------------
module ir_block_loader
  import ir_block_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = IR_DATA_WIDTH,
  parameter int ADDR_WIDTH   = IR_ADDR_WIDTH,
  parameter int CACHE_RD_LAT = 1,
  parameter int INIT_SRC     = 0,
  parameter int INIT_DST     = 0,
  parameter int INIT_LINES   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_init,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_read_p,
  output logic                  o_cache_ren,
  output logic [ADDR_WIDTH-1:0] o_cache_addr,
  input  logic [DATA_WIDTH-1:0] i_cache_data,
  output logic                  o_ir_wen,
  output logic [ADDR_WIDTH-1:0] o_ir_addr,
  output logic [DATA_WIDTH-1:0] o_ir_wdata,
`ifdef IR_LOAD_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] o_checksum,
`endif
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0]    INIT_SRC_A   = ADDR_WIDTH'(INIT_SRC);
  localparam logic [ADDR_WIDTH-1:0]    INIT_DST_A   = ADDR_WIDTH'(INIT_DST);
  localparam logic [ADDR_WIDTH-1:0]    INIT_CNT_A   = ADDR_WIDTH'(INIT_LINES);
  localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD_VAL = LAT_CNT_WIDTH'(CACHE_RD_LAT - 1);

  ir_load_state_e        state_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] cnt_q;

  // Parameter word seen as an address/count: truncated or zero-extended.
  logic [ADDR_WIDTH-1:0] data_addr;

  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_data_trunc
      assign data_addr = i_data[ADDR_WIDTH-1:0];
    end else begin : g_data_zext
      assign data_addr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, i_data};
    end
  endgenerate

  // Latency counter: loaded in ISSUE, counted down in WAIT.
  logic [LAT_CNT_WIDTH-1:0] lat_count;
  logic                     lat_zero;
  logic                     lat_last;

  ir_load_latency_cnt #(
    .WIDTH (LAT_CNT_WIDTH)
  ) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_q == S_ISSUE),
    .load_val_i (LAT_LOAD_VAL),
    .dec_i      (state_q == S_WAIT),
    .count_o    (lat_count),
    .zero_o     (lat_zero),
    .last_o     (lat_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else if (i_abort && (state_q != S_IDLE)) begin
      // Any outstanding cache read is simply never consumed.
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_init) begin
            state_q <= S_INIT;
          end else if (i_en) begin
            state_q <= S_RD_P0;
          end
        end
        S_INIT: begin
          src_q   <= INIT_SRC_A;
          dst_q   <= INIT_DST_A;
          cnt_q   <= INIT_CNT_A;
          state_q <= (INIT_CNT_A == '0) ? S_DONE : S_ISSUE;
        end
        S_RD_P0: begin
          src_q   <= data_addr;
          state_q <= S_RD_P1;
        end
        S_RD_P1: begin
          dst_q   <= data_addr;
          state_q <= S_RD_P2;
        end
        S_RD_P2: begin
          cnt_q   <= data_addr;
          state_q <= (data_addr != '0) ? S_ISSUE : S_DONE;
        end
        S_ISSUE: begin
          state_q <= (CACHE_RD_LAT == 1) ? S_WRITE : S_WAIT;
        end
        S_WAIT: begin
          // The counter holds LAT-1 on the first WAIT cycle; leave on the
          // cycle that takes it to zero so each word costs 1+LAT cycles.
          if (lat_last || lat_zero) begin
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          src_q   <= src_q + ADDR_WIDTH'(1);
          dst_q   <= dst_q + ADDR_WIDTH'(1);
          cnt_q   <= cnt_q - ADDR_WIDTH'(1);
          state_q <= (cnt_q == ADDR_WIDTH'(1)) ? S_DONE : S_ISSUE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode of the registered state; all zero in IDLE (and so in reset).
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_read_p     = (state_q == S_RD_P0) || (state_q == S_RD_P1) ||
                        (state_q == S_RD_P2);
  assign o_cache_ren  = (state_q == S_ISSUE);
  assign o_cache_addr = (state_q == S_ISSUE) ? src_q : '0;
  assign o_ir_wen     = (state_q == S_WRITE);
  assign o_ir_addr    = (state_q == S_WRITE) ? dst_q : '0;
  // The cache read port is registered on the cache side, so forwarding its
  // data during WRITE does not lengthen any path inside this block.
  assign o_ir_wdata   = (state_q == S_WRITE) ? i_cache_data : '0;

`ifdef IR_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if ((state_q == S_IDLE) && (i_init || i_en)) begin
      checksum_q <= '0;
    end else if ((state_q == S_WRITE) && !i_abort) begin
      checksum_q <= checksum_q ^ i_cache_data;
    end
  end

  assign o_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_ir_block_loader.sv
module tb_ir_block_loader;

  localparam int DW = 8;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: CACHE_RD_LAT=1 ----------------
  logic          a_en = 0, a_init = 0, a_abort = 0;
  logic [DW-1:0] a_data = '0;
  logic          a_read_p, a_ren, a_wen, a_busy, a_done;
  logic [AW-1:0] a_caddr, a_waddr;
  logic [DW-1:0] a_cdata = '0, a_wdata;
`ifdef IR_LOAD_CHECKSUM_EN
  logic [DW-1:0] a_cks, b_cks;
`endif

  ir_block_loader #(.CACHE_RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_en(a_en), .i_init(a_init), .i_abort(a_abort),
    .i_data(a_data), .o_read_p(a_read_p), .o_cache_ren(a_ren),
    .o_cache_addr(a_caddr), .i_cache_data(a_cdata), .o_ir_wen(a_wen),
    .o_ir_addr(a_waddr), .o_ir_wdata(a_wdata),
`ifdef IR_LOAD_CHECKSUM_EN
    .o_checksum(a_cks),
`endif
    .o_busy(a_busy), .o_done(a_done)
  );

  // ---------------- DUT B: CACHE_RD_LAT=3 ----------------
  logic          b_en = 0, b_init = 0, b_abort = 0;
  logic [DW-1:0] b_data = '0;
  logic          b_read_p, b_ren, b_wen, b_busy, b_done;
  logic [AW-1:0] b_caddr, b_waddr;
  logic [DW-1:0] b_cdata = '0, b_wdata;

  ir_block_loader #(.CACHE_RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_en(b_en), .i_init(b_init), .i_abort(b_abort),
    .i_data(b_data), .o_read_p(b_read_p), .o_cache_ren(b_ren),
    .o_cache_addr(b_caddr), .i_cache_data(b_cdata), .o_ir_wen(b_wen),
    .o_ir_addr(b_waddr), .o_ir_wdata(b_wdata),
`ifdef IR_LOAD_CHECKSUM_EN
    .o_checksum(b_cks),
`endif
    .o_busy(b_busy), .o_done(b_done)
  );

  // ---------------- cache models ----------------
  logic [DW-1:0] mem [256];
  logic [DW-1:0] b_p1 = '0, b_p2 = '0;

  always @(posedge clk) begin
    a_cdata <= a_ren ? mem[a_caddr] : 8'h00;
    b_p1    <= b_ren ? mem[b_caddr] : 8'h00;
    b_p2    <= b_p1;
    b_cdata <= b_p2;
  end

  // ---------------- parameter-word drivers ----------------
  logic [DW-1:0] a_pq[$], b_pq[$];
  int a_rp_cnt = 0, b_rp_cnt = 0;

  always @(negedge clk) begin
    if (a_read_p) begin
      a_rp_cnt = a_rp_cnt + 1;
      a_data = (a_pq.size() > 0) ? a_pq.pop_front() : 8'h00;
    end
    if (b_read_p) begin
      b_rp_cnt = b_rp_cnt + 1;
      b_data = (b_pq.size() > 0) ? b_pq.pop_front() : 8'h00;
    end
  end

  // ---------------- event logs ----------------
  int            a_wc_q[$], a_rc_q[$], a_dc_q[$];
  logic [AW-1:0] a_wa_q[$], a_ra_q[$];
  logic [DW-1:0] a_wd_q[$];
  int            b_wc_q[$], b_rc_q[$], b_dc_q[$];
  logic [AW-1:0] b_wa_q[$], b_ra_q[$];
  logic [DW-1:0] b_wd_q[$];

  always @(negedge clk) begin
    if (a_wen) begin a_wc_q.push_back(cyc); a_wa_q.push_back(a_waddr); a_wd_q.push_back(a_wdata); end
    if (a_ren) begin a_rc_q.push_back(cyc); a_ra_q.push_back(a_caddr); end
    if (a_done) a_dc_q.push_back(cyc);
    if (b_wen) begin b_wc_q.push_back(cyc); b_wa_q.push_back(b_waddr); b_wd_q.push_back(b_wdata); end
    if (b_ren) begin b_rc_q.push_back(cyc); b_ra_q.push_back(b_caddr); end
    if (b_done) b_dc_q.push_back(cyc);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  int s_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    a_wc_q.delete(); a_rc_q.delete(); a_dc_q.delete();
    a_wa_q.delete(); a_ra_q.delete(); a_wd_q.delete();
    b_wc_q.delete(); b_rc_q.delete(); b_dc_q.delete();
    b_wa_q.delete(); b_ra_q.delete(); b_wd_q.delete();
    a_rp_cnt = 0; b_rp_cnt = 0;
    exp_q.delete();
  endtask

  task automatic start_a(input logic init, input logic en);
    @(negedge clk);
    a_init = init; a_en = en; s_cyc = cyc;
    @(negedge clk);
    a_init = 1'b0; a_en = 1'b0;
  endtask

  task automatic start_b();
    @(negedge clk);
    b_en = 1'b1; s_cyc = cyc;
    @(negedge clk);
    b_en = 1'b0;
  endtask

  task automatic wait_a_idle(input string tag, input int budget);
    int n = 0;
    while (a_busy && n < budget) begin @(negedge clk); n++; end
    check({tag, "_timeout"}, 32'(a_busy), 32'd0);
  endtask

  task automatic wait_b_idle(input string tag, input int budget);
    int n = 0;
    while (b_busy && n < budget) begin @(negedge clk); n++; end
    check({tag, "_timeout"}, 32'(b_busy), 32'd0);
  endtask

  task automatic check_a_quiet(input string tag);
    check({tag, "_read_p"}, 32'(a_read_p), 0);
    check({tag, "_ren"},    32'(a_ren),    0);
    check({tag, "_caddr"},  32'(a_caddr),  0);
    check({tag, "_wen"},    32'(a_wen),    0);
    check({tag, "_waddr"},  32'(a_waddr),  0);
    check({tag, "_wdata"},  32'(a_wdata),  0);
    check({tag, "_busy"},   32'(a_busy),   0);
    check({tag, "_done"},   32'(a_done),   0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int errs;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);

    // reset
    tick(3);
    check_a_quiet("reset");
    check("reset_b_busy", 32'(b_busy), 0);
`ifdef IR_LOAD_CHECKSUM_EN
    check("reset_cks", 32'(a_cks), 0);
`endif
    rst_n = 1'b1;
    tick(2);

    // T1: LAT=1, src 0x10, dst 0x20, cnt 3
    clear_logs();
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hA2; mem[8'h12] = 8'hA3;
    exp_q = '{8'hA1, 8'hA2, 8'hA3};
    a_pq = '{8'h10, 8'h20, 8'h03};
    start_a(1'b0, 1'b1);
    wait_a_idle("t1", 40);
    tick(2);
    check("t1_nwr", a_wa_q.size(), 3);
    for (int i = 0; i < 3 && i < a_wa_q.size(); i++) begin
      check("t1_waddr", 32'(a_wa_q[i]), 32'h20 + i);
      check("t1_wdata", 32'(a_wd_q[i]), 32'(exp_q[i]));
      check("t1_wcyc",  a_wc_q[i] - s_cyc, 5 + 2 * i);
      if (i < a_ra_q.size()) check("t1_raddr", 32'(a_ra_q[i]), 32'h10 + i);
    end
    check("t1_nrd", a_ra_q.size(), 3);
    check("t1_ndone", a_dc_q.size(), 1);
    if (a_dc_q.size() > 0) check("t1_done_cyc", a_dc_q[0] - s_cyc, 10);
    check("t1_nread_p", a_rp_cnt, 3);

    // T2: cnt = 0
    clear_logs();
    a_pq = '{8'h05, 8'h06, 8'h00};
    start_a(1'b0, 1'b1);
    wait_a_idle("t2", 20);
    tick(2);
    check("t2_nrd", a_ra_q.size(), 0);
    check("t2_nwr", a_wa_q.size(), 0);
    check("t2_ndone", a_dc_q.size(), 1);
    if (a_dc_q.size() > 0) check("t2_done_cyc", a_dc_q[0] - s_cyc, 4);

    // T3: i_init and i_en together -> init load of 255 words
    clear_logs();
    start_a(1'b1, 1'b1);
    wait_a_idle("t3", 600);
    tick(2);
    check("t3_nwr", a_wa_q.size(), 255);
    errs = 0;
    for (int i = 0; i < a_wa_q.size(); i++) begin
      if (a_wa_q[i] !== 8'(i) || a_wd_q[i] !== mem[i]) errs++;
    end
    check("t3_word_errs", errs, 0);
    check("t3_nread_p", a_rp_cnt, 0);
    check("t3_ndone", a_dc_q.size(), 1);
    if (a_dc_q.size() > 0) check("t3_done_cyc", a_dc_q[0] - s_cyc, 512);

    // T4: LAT=3, src 0xFE wraps, dst 0x40, cnt 3
    clear_logs();
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    exp_q = '{8'h11, 8'h22, 8'h33};
    b_pq = '{8'hFE, 8'h40, 8'h03};
    start_b();
    wait_b_idle("t4", 40);
    tick(2);
    check("t4_nrd", b_ra_q.size(), 3);
    if (b_ra_q.size() == 3) begin
      check("t4_raddr0", 32'(b_ra_q[0]), 32'hFE);
      check("t4_raddr1", 32'(b_ra_q[1]), 32'hFF);
      check("t4_raddr2", 32'(b_ra_q[2]), 32'h00);
    end
    check("t4_nwr", b_wa_q.size(), 3);
    for (int i = 0; i < 3 && i < b_wa_q.size(); i++) begin
      check("t4_waddr", 32'(b_wa_q[i]), 32'h40 + i);
      check("t4_wdata", 32'(b_wd_q[i]), 32'(exp_q[i]));
      check("t4_wcyc",  b_wc_q[i] - s_cyc, 7 + 4 * i);
    end
    check("t4_ndone", b_dc_q.size(), 1);
    if (b_dc_q.size() > 0) check("t4_done_cyc", b_dc_q[0] - s_cyc, 16);

    // T5: abort in WAIT of word 2, then a fresh transfer
    clear_logs();
    b_pq = '{8'h30, 8'h50, 8'h04};
    start_b();
    while (cyc < s_cyc + 9) tick(1);
    b_abort = 1'b1;
    tick(1);
    b_abort = 1'b0;
    check("t5_busy_after_abort", 32'(b_busy), 0);
    tick(10);
    check("t5_nwr", b_wa_q.size(), 1);
    if (b_wa_q.size() > 0) begin
      check("t5_waddr", 32'(b_wa_q[0]), 32'h50);
      check("t5_wdata", 32'(b_wd_q[0]), 32'(mem[8'h30]));
    end
    check("t5_ndone", b_dc_q.size(), 0);
    clear_logs();
    b_pq = '{8'h60, 8'h70, 8'h01};
    start_b();
    wait_b_idle("t5b", 30);
    tick(2);
    check("t5b_nwr", b_wa_q.size(), 1);
    if (b_wa_q.size() > 0) begin
      check("t5b_waddr", 32'(b_wa_q[0]), 32'h70);
      check("t5b_wdata", 32'(b_wd_q[0]), 32'(mem[8'h60]));
    end
    check("t5b_ndone", b_dc_q.size(), 1);

    // T6: reset for one cycle mid-transfer
    clear_logs();
    a_pq = '{8'h10, 8'h20, 8'h03};
    start_a(1'b0, 1'b1);
    while (cyc < s_cyc + 4) tick(1);
    rst_n = 1'b0;
    tick(1);
    check_a_quiet("t6_rst");
    rst_n = 1'b1;
    tick(12);
    check("t6_nwr", a_wa_q.size(), 0);
    check("t6_ndone", a_dc_q.size(), 0);

    // T7: two-word transfer 0x5A, 0x3C
    clear_logs();
    mem[8'h80] = 8'h5A; mem[8'h81] = 8'h3C;
    a_pq = '{8'h80, 8'h90, 8'h02};
    start_a(1'b0, 1'b1);
    wait_a_idle("t7", 20);
    tick(3);
    check("t7_nwr", a_wa_q.size(), 2);
    if (a_wd_q.size() == 2) begin
      check("t7_wdata0", 32'(a_wd_q[0]), 32'h5A);
      check("t7_wdata1", 32'(a_wd_q[1]), 32'h3C);
    end
`ifdef IR_LOAD_CHECKSUM_EN
    check("t7_checksum", 32'(a_cks), 32'h66);
    tick(3);
    check("t7_checksum_hold", 32'(a_cks), 32'h66);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
